// File: rtl/mux_wh_arbiter.sv
// Wormhole round-robin arbiter with downstream credit tracking for an N:1 output mux.
// A packet owns the output from its HEAD flit through its TAIL flit.

module mux_wh_lane #(
  parameter int TYPEW = 2
) (
  input  logic             vld_i,
  input  logic [TYPEW-1:0] type_i,
  output logic             head_o,
  output logic             tail_o,
  output logic             bad_o
);
  assign head_o = vld_i && (type_i == TYPEW'(1));
  assign tail_o = vld_i && (type_i == TYPEW'(3));
  assign bad_o  = vld_i && (type_i != TYPEW'(1));
endmodule

module mux_wh_arbiter #(
  parameter int NPORT   = 2,
  parameter int TYPEW   = 2,
  parameter int CREDITS = 4,
  parameter int CNTW    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT-1:0]       ivalid,
  input  logic [NPORT*TYPEW-1:0] itype,
  input  logic                   credit_in,
  output logic [NPORT-1:0]       sel,
  output logic [NPORT-1:0]       ack,
  output logic                   ofwd,
  output logic                   busy,
  output logic [CNTW-1:0]        credit_cnt,
  output logic                   err
);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d, rr_q, rr_d;
  logic [NPORT-1:0] sel_q, sel_d;
  logic             busy_q, busy_d, first_q, first_d, err_q, err_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [NPORT-1:0] head, tail, bad;
  logic             fwd, grant_vld;
  logic [PW-1:0]    grant_idx, scan;

  for (genvar k = 0; k < NPORT; k++) begin : g_lane
    mux_wh_lane #(.TYPEW(TYPEW)) u_lane (
      .vld_i (ivalid[k]),
      .type_i(itype[k*TYPEW +: TYPEW]),
      .head_o(head[k]),
      .tail_o(tail[k]),
      .bad_o (bad[k])
    );
  end

  // Round-robin search for the first HEAD at or after rr_q, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = rr_q;
    for (int i = 0; i < NPORT; i++) begin
      if (!grant_vld && head[scan]) begin
        grant_vld = 1'b1;
        grant_idx = scan;
      end
      scan = (scan == PW'(NPORT-1)) ? '0 : scan + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= CNTW'(CREDITS);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    first_d = first_q;
    case (state_q)
      IDLE: if (grant_vld) begin
        state_d = LOCKED;
        owner_d = grant_idx;
        first_d = 1'b0;
      end
      LOCKED: begin
        if (fwd) first_d = 1'b1;
        if (fwd && tail[owner_q]) begin
          state_d = IDLE;
          rr_d    = (owner_q == PW'(NPORT-1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    sel_d  = (state_d == LOCKED) ? (NPORT'(1) << owner_d) : '0;
    busy_d = (state_d == LOCKED);

    // Saturating credit counter; a return into a full counter is a protocol error.
    cnt_d = cnt_q;
    err_d = err_q;
    if (fwd && !credit_in)
      cnt_d = cnt_q - 1'b1;
    else if (!fwd && credit_in) begin
      if (cnt_q == CNTW'(CREDITS)) err_d = 1'b1;
      else                         cnt_d = cnt_q + 1'b1;
    end
    if (state_q == IDLE && bad[rr_q])                  err_d = 1'b1;
    if (state_q == LOCKED && first_q && head[owner_q]) err_d = 1'b1;
  end

  always_comb begin
    fwd  = (state_q == LOCKED) && ivalid[owner_q] && (cnt_q != '0);
    ack  = fwd ? (NPORT'(1) << owner_q) : '0;
    ofwd = fwd;
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign credit_cnt = cnt_q;
  assign err        = err_q;
endmodule

// File: tb/tb_mux_wh_arbiter.sv
// Directed bench for mux_wh_arbiter: a vector table for two competing packets,
// plus hand sequences for long packets, starvation, stalls, reset and errors.

module tb_mux_wh_arbiter;
  localparam int NPORT = 2, TYPEW = 2, CREDITS = 4, CNTW = 3;
  localparam logic [1:0] TN = 2'b00, TH = 2'b01, TD = 2'b10, TT = 2'b11;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NPORT-1:0]       ivalid;
  logic [NPORT*TYPEW-1:0] itype;
  logic                   credit_in;
  logic [NPORT-1:0]       sel, ack;
  logic                   ofwd, busy, err;
  logic [CNTW-1:0]        credit_cnt;

  mux_wh_arbiter #(.NPORT(NPORT), .TYPEW(TYPEW), .CREDITS(CREDITS), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .itype(itype), .credit_in(credit_in),
    .sel(sel), .ack(ack), .ofwd(ofwd), .busy(busy), .credit_cnt(credit_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] iv;
    logic [3:0] it;
    logic       cin;
    logic [1:0] ack;
    logic [1:0] sel;
    logic       busy;
    logic [2:0] cnt;
    logic       err;
  } vec_t;

  vec_t tbl[9];
  int tests = 0, fails = 0;
  int f, nacks, mcnt;
  logic [1:0] pend;
  logic cin, expack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] iv, input logic [3:0] it, input logic c);
    ivalid = iv; itype = it; credit_in = c;
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    ivalid = '0; itype = '0; credit_in = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Input 0 and 1 both raise HEAD; input 0 wins, then input 1 after one bubble.
    tbl[0] = '{2'b11, {TH,TH}, 1'b0, 2'b00, 2'b00, 1'b0, 3'd4, 1'b0};
    tbl[1] = '{2'b11, {TH,TH}, 1'b0, 2'b01, 2'b01, 1'b1, 3'd4, 1'b0};
    tbl[2] = '{2'b11, {TH,TD}, 1'b0, 2'b01, 2'b01, 1'b1, 3'd3, 1'b0};
    tbl[3] = '{2'b11, {TH,TT}, 1'b0, 2'b01, 2'b01, 1'b1, 3'd2, 1'b0};
    tbl[4] = '{2'b10, {TH,TN}, 1'b1, 2'b00, 2'b00, 1'b0, 3'd1, 1'b0};
    tbl[5] = '{2'b10, {TH,TN}, 1'b0, 2'b10, 2'b10, 1'b1, 3'd2, 1'b0};
    tbl[6] = '{2'b10, {TT,TN}, 1'b0, 2'b10, 2'b10, 1'b1, 3'd1, 1'b0};
    tbl[7] = '{2'b00, {TN,TN}, 1'b1, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0};
    tbl[8] = '{2'b00, {TN,TN}, 1'b1, 2'b00, 2'b00, 1'b0, 3'd1, 1'b0};

    // Reset state
    rst = 1'b1; ivalid = '0; itype = '0; credit_in = 1'b0;
    #1;
    chk("rst sel", 32'(sel), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst cnt", 32'(credit_cnt), 4);
    chk("rst err", 32'(err), 0);
    chk("rst ack", 32'(ack), 0);
    chk("rst ofwd", 32'(ofwd), 0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].iv, tbl[i].it, tbl[i].cin);
      chk($sformatf("tbl[%0d] ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("tbl[%0d] sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("tbl[%0d] busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl[%0d] cnt", i), 32'(credit_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl[%0d] err", i), 32'(err), 32'(tbl[i].err));
      step();
    end

    // Long packet on input 1, credits returned two cycles after each ack
    reset_dut();
    f = 0; nacks = 0; mcnt = CREDITS; pend = 2'b00;
    for (int c = 0; c < 25; c++) begin
      cin = pend[1];
      drive((f < 22) ? 2'b10 : 2'b00,
            {(f == 0) ? TH : ((f == 21) ? TT : TD), TN}, cin);
      expack = (c >= 1 && c <= 22);
      chk("long ack", 32'(ack), expack ? 2 : 0);
      chk("long cnt", 32'(credit_cnt), 32'(mcnt));
      if (c == 1) chk("long sel", 32'(sel), 2);
      if (c == 23) begin
        chk("long busy end", 32'(busy), 0);
        chk("long sel end", 32'(sel), 0);
      end
      if (ack[1]) begin f++; nacks++; end
      mcnt = mcnt - int'(expack) + int'(cin);
      pend = {pend[0], expack};
      step();
    end
    chk("long acks", 32'(nacks), 22);
    chk("long cnt final", 32'(credit_cnt), 4);
    chk("long err", 32'(err), 0);

    // Credit starvation
    reset_dut();
    drive(2'b01, {TN,TH}, 1'b0); chk("starve ack0", 32'(ack), 0); step();
    drive(2'b01, {TN,TH}, 1'b0); chk("starve ack1", 32'(ack), 1); step();
    for (int c = 2; c < 5; c++) begin
      drive(2'b01, {TN,TD}, 1'b0); chk("starve ack", 32'(ack), 1); step();
    end
    drive(2'b01, {TN,TD}, 1'b1);
    chk("starve cnt0", 32'(credit_cnt), 0);
    chk("starve noack", 32'(ack), 0);
    chk("starve busy", 32'(busy), 1);
    step();
    drive(2'b01, {TN,TD}, 1'b0);
    chk("starve cnt1", 32'(credit_cnt), 1);
    chk("starve resume", 32'(ack), 1);
    step();
    drive(2'b01, {TN,TD}, 1'b0);
    chk("starve cnt back", 32'(credit_cnt), 0);
    chk("starve ack again", 32'(ack), 0);
    chk("starve ofwd", 32'(ofwd), 0);
    chk("starve busy held", 32'(busy), 1);
    step();

    // Owner stalls while input 0 waits with HEAD
    reset_dut();
    drive(2'b10, {TH,TN}, 1'b0); chk("stall ack0", 32'(ack), 0); step();
    drive(2'b11, {TH,TH}, 1'b0); chk("stall head", 32'(ack), 2); step();
    drive(2'b11, {TD,TH}, 1'b0); chk("stall d1", 32'(ack), 2); step();
    for (int c = 0; c < 3; c++) begin
      drive(2'b01, {TD,TH}, 1'b0);
      chk("stall noack", 32'(ack), 0);
      chk("stall sel", 32'(sel), 2);
      chk("stall cnt", 32'(credit_cnt), 2);
      step();
    end
    drive(2'b11, {TD,TH}, 1'b0); chk("stall resume", 32'(ack), 2); step();
    drive(2'b11, {TT,TH}, 1'b0); chk("stall tail", 32'(ack), 2); step();
    drive(2'b01, {TN,TH}, 1'b0);
    chk("stall idle busy", 32'(busy), 0);
    chk("stall idle ack", 32'(ack), 0);
    step();
    drive(2'b01, {TN,TH}, 1'b0);
    chk("stall next sel", 32'(sel), 1);
    chk("stall next ack", 32'(ack), 0);
    chk("stall err", 32'(err), 0);
    step();

    // Reset in mid-packet
    reset_dut();
    drive(2'b01, {TN,TH}, 1'b0); step();
    drive(2'b01, {TN,TH}, 1'b0); chk("mid ack h", 32'(ack), 1); step();
    drive(2'b01, {TN,TD}, 1'b0); chk("mid ack d", 32'(ack), 1);
    rst = 1'b1; #1;
    chk("mid rst sel", 32'(sel), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst cnt", 32'(credit_cnt), 4);
    chk("mid rst ack", 32'(ack), 0);
    step();
    rst = 1'b0;
    drive(2'b10, {TH,TN}, 1'b0); chk("post rst idle", 32'(ack), 0); step();
    drive(2'b10, {TH,TN}, 1'b0);
    chk("post rst sel", 32'(sel), 2);
    chk("post rst ack", 32'(ack), 2);
    chk("post rst err", 32'(err), 0);
    step();

    // Protocol errors
    reset_dut();
    drive(2'b01, {TN,TD}, 1'b0);
    chk("perr ack", 32'(ack), 0);
    chk("perr err pre", 32'(err), 0);
    step();
    drive(2'b00, {TN,TN}, 1'b0);
    chk("perr err set", 32'(err), 1);
    chk("perr busy", 32'(busy), 0);
    step(); step(); step();
    chk("perr sticky", 32'(err), 1);
    reset_dut();
    chk("perr cleared", 32'(err), 0);
    drive(2'b00, {TN,TN}, 1'b1); step();
    drive(2'b00, {TN,TN}, 1'b0);
    chk("cred ovf err", 32'(err), 1);
    chk("cred ovf cnt", 32'(credit_cnt), 4);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux_wh_arbiter.md
Name: mux_wh_arbiter

Overview:
- Packet-level (wormhole) round-robin arbiter and credit controller for the router's N:1 output mux.
- Watches head/data/tail flit types on each mux input and drives the mux one-hot `sel`.
- Holds a grant from head flit to tail flit and gates forwarding on downstream buffer credits.
- Returns per-input `ack` so the upstream input buffer pops exactly one flit per transfer.

Parameters:
- NPORT, 2, number of mux inputs (one-hot `sel` width).
- TYPEW, 2, flit type field width (MSBs of each flit).
- CREDITS, 4, downstream buffer depth; reset value and ceiling of the credit counter.
- CNTW, 3, credit counter width; must hold CREDITS.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ivalid  in  NPORT  per-input flit valid; input holds its flit stable until acked.
- itype  in  NPORT*TYPEW  per-input flit type, input k at [k*TYPEW +: TYPEW]; encoding: 00 NONE, 01 HEAD, 10 DATA, 11 TAIL.
- credit_in  in  1  one-cycle pulse, one downstream slot freed.
- sel  out  NPORT  registered one-hot mux select; all-zero when idle.
- ack  out  NPORT  combinational; bit k=1 means input k's flit is transferred this cycle.
- ofwd  out  1  combinational; gates mux `ovalid` (=|ack).
- busy  out  1  registered; 1 while a packet owns the output.
- credit_cnt  out  CNTW  registered available credits.
- err  out  1  sticky protocol error, cleared only by rst.

Behaviour:
- Reset (async, immediate):
  - sel=0, busy=0, state IDLE, owner=0, rr pointer=0.
  - credit_cnt=CREDITS, err=0.
  - ack/ofwd=0 because busy=0.
- State machine, two states:
  - IDLE:
    - Candidates are inputs with ivalid=1 and itype=HEAD.
    - If any candidate exists, grant the first at or after rr pointer (wrapping).
    - Next cycle: state LOCKED, sel=onehot(owner), busy=1.
    - Credits are not checked at grant time.
    - No ack in IDLE.
  - LOCKED:
    - fwd = ivalid[owner] & (credit_cnt!=0).
    - ack[owner]=fwd; all other ack bits 0. The head flit is forwarded in the first LOCKED cycle.
    - If fwd and itype[owner]==TAIL: next cycle IDLE, sel=0, busy=0, rr pointer=(owner+1) mod NPORT.
- Latency: head present in IDLE cycle N → sel valid and head acked earliest at cycle N+1. Tail acked at cycle M → new grant decided at M+1 → forwarding at M+2. There is a one-cycle bubble between packets.
- Credits:
  - credit_cnt_next = credit_cnt - fwd + credit_in.
  - credit_in arriving while credit_cnt==0 is not usable until the next cycle.
  - credit_in with credit_cnt==CREDITS and no fwd: the counter stays at CREDITS and err is set.
- Protocol errors (set err; no other state change):
  - In IDLE, the flit at the rr-pointer input has ivalid=1 with type DATA/TAIL/NONE. That flit is not acked, and arbitration over the other inputs proceeds normally.
  - In LOCKED, the owner presents HEAD after its first flit has been acked. The flit is forwarded anyway.
- Non-owner inputs are never acked while LOCKED, even if valid.
- The owner deasserting ivalid mid-packet is legal: no ack, lock held, no credit consumed.
- Reset mid-packet: lock dropped immediately. Upstream retransmission is outside this block.

Test Plan:
- Single packet (HEAD, 20 DATA, TAIL) on input 1, input 0 idle, CREDITS=4, credit_in pulsed 2 cycles after each ack:
  - sel=2'b10 one cycle after head, 22 acks total.
  - credit_cnt never below 0; busy falls one cycle after tail ack; sel=2'b00.
- Both inputs present HEAD in the same cycle after reset:
  - input 0 granted first, with its full packet.
  - input 1 granted on the cycle after input 0's IDLE cycle.
  - err=0.
- Credit starvation: 4 flits forwarded with no credit_in:
  - credit_cnt=0, ack=0, busy held.
  - credit_in pulse → ack one cycle later; credit_cnt returns to 0.
- Owner ivalid dropped for 3 cycles mid-packet while input 0 holds a HEAD:
  - no ack to either input, sel unchanged.
  - transfer resumes on the owner.
- Assert rst for 1 cycle in mid-packet:
  - sel=0, busy=0, credit_cnt=4 immediately.
  - fresh HEAD granted normally after reset.
- Protocol error checks:
  - DATA presented at the rr-pointer input while IDLE → err=1, no ack, and it stays 1 until rst.
  - credit_in at credit_cnt=4 with no fwd → err=1.
